y86_regfile_pipe: RTL and testbench

//  Parametrised Y86-64 register file for the pipelined core; successor of the single-cycle register file.
//  Two combinational read ports (A/B), two write ports (E from execute, M from memory) with optional write->read bypass.
//  Per-register pending-write scoreboard lets decode detect data hazards and drive stall logic.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/y86_reg_scoreboard.sv | 109 ++++++++++
 rtl/y86_regfile_pipe.sv | 101 ++++++++++
 tb/tb_y86_regfile_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register specifiers, default widths and instruction codes.
package y86_pkg;

    localparam int unsigned Y86_DATA_W   = 64;
    localparam int unsigned Y86_ADDR_W   = 4;
    localparam int unsigned Y86_NUM_REGS = 15;
    localparam int unsigned Y86_RSP_IDX  = 4;
    localparam logic [3:0]  Y86_RNONE    = 4'hF;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    // Write-port payload at the default register-file geometry.
    typedef struct packed {
        logic                  en;
        logic [Y86_ADDR_W-1:0] dst;
        logic [Y86_DATA_W-1:0] val;
    } wr_port_t;

endpackage

// File: rtl/y86_reg_scoreboard.sv
// Per-register pending-write counters: reservations increment, writes decrement,
// busy lookup for both read ports and a sticky error on overflow/underflow.
module y86_reg_scoreboard
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W   = Y86_ADDR_W,
    parameter int unsigned NUM_REGS = Y86_NUM_REGS,
    parameter int unsigned PEND_W   = 2,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    input  logic              wenE,
    input  logic [ADDR_W-1:0] dstE,
    input  logic              wenM,
    input  logic [ADDR_W-1:0] dstM,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_dstE,
    input  logic [ADDR_W-1:0] rsv_dstM,
    output logic              busyA,
    output logic              busyB,
    output logic              sb_err
);

    localparam int unsigned       CW      = PEND_W + 2;
    localparam logic [CW-1:0]     CNT_MAX = CW'((1 << PEND_W) - 1);
    localparam logic [ADDR_W:0]   NREG    = (ADDR_W + 1)'(NUM_REGS);

    logic [PEND_W-1:0] cnt_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_d [NUM_REGS];
    logic              err_q;
    logic              err_d;
    logic [1:0]        inc;
    logic [1:0]        dec;
    logic [CW-1:0]     sum;
    logic [CW-1:0]     diff;

    // Net per-register update; a negative result clamps to 0, a large one saturates.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        inc   = '0;
        dec   = '0;
        sum   = '0;
        diff  = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            inc = 2'(rsv_en && (rsv_dstE == ADDR_W'(r))) + 2'(rsv_en && (rsv_dstM == ADDR_W'(r)));
            dec = 2'(wenE && (dstE == ADDR_W'(r))) + 2'(wenM && (dstM == ADDR_W'(r)));
            sum = CW'(cnt_q[r]) + CW'(inc);
            if (CW'(dec) > sum) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                diff = sum - CW'(dec);
                if (diff > CNT_MAX) begin
                    cnt_d[r] = '1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d[r] = PEND_W'(diff);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    logic [PEND_W-1:0] cnt_a;
    logic [PEND_W-1:0] cnt_b;
    logic [1:0]        wr_a;
    logic [1:0]        wr_b;
    logic              ok_a;
    logic              ok_b;

    // With bypass, a write landing this cycle already satisfies one pending count.
    always_comb begin
        cnt_a = '0;
        cnt_b = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (srcA == ADDR_W'(r)) cnt_a = cnt_q[r];
            if (srcB == ADDR_W'(r)) cnt_b = cnt_q[r];
        end
        ok_a = {1'b0, srcA} < NREG;
        ok_b = {1'b0, srcB} < NREG;
        wr_a = 2'(wenE && (dstE == srcA)) + 2'(wenM && (dstM == srcA));
        wr_b = 2'(wenE && (dstE == srcB)) + 2'(wenM && (dstM == srcB));
        if (BYPASS != 0) begin
            busyA = ok_a && (CW'(cnt_a) != CW'(wr_a));
            busyB = ok_b && (CW'(cnt_b) != CW'(wr_b));
        end else begin
            busyA = ok_a && (cnt_a != '0);
            busyB = ok_b && (cnt_b != '0);
        end
    end

    assign sb_err = err_q;

endmodule

// File: rtl/y86_regfile_pipe.sv
// Pipelined Y86-64 register file: two combinational read ports, E/M write ports
// with M-over-E priority, optional write-to-read bypass and a pending-write scoreboard.
module y86_regfile_pipe
    import y86_pkg::*;
#(
    parameter int unsigned        DATA_W    = Y86_DATA_W,
    parameter int unsigned        ADDR_W    = Y86_ADDR_W,
    parameter int unsigned        NUM_REGS  = Y86_NUM_REGS,
    parameter int unsigned        RSP_IDX   = Y86_RSP_IDX,
    parameter logic [DATA_W-1:0]  RSP_RESET = DATA_W'(65535),
    parameter int unsigned        BYPASS    = 1,
    parameter int unsigned        PEND_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              busyA,
    output logic              busyB,
    input  logic              wenE,
    input  logic [ADDR_W-1:0] dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic              wenM,
    input  logic [ADDR_W-1:0] dstM,
    input  logic [DATA_W-1:0] valM,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_dstE,
    input  logic [ADDR_W-1:0] rsv_dstM,
    output logic              sb_err
);

    localparam logic [ADDR_W:0] NREG = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // M is applied after E so a same-register collision keeps valM (popq %rsp).
    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (wenE && (dstE == ADDR_W'(r))) regs_d[r] = valE;
            if (wenM && (dstM == ADDR_W'(r))) regs_d[r] = valM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= (r == int'(RSP_IDX)) ? RSP_RESET : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic ok_a;
    logic ok_b;

    // Out-of-range specifiers (including RNONE) read as zero and never bypass.
    always_comb begin
        valA = '0;
        valB = '0;
        ok_a = {1'b0, srcA} < NREG;
        ok_b = {1'b0, srcB} < NREG;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (srcA == ADDR_W'(r)) valA = regs_q[r];
            if (srcB == ADDR_W'(r)) valB = regs_q[r];
        end
        if (BYPASS != 0) begin
            if (ok_a && wenM && (dstM == srcA))      valA = valM;
            else if (ok_a && wenE && (dstE == srcA)) valA = valE;
            if (ok_b && wenM && (dstM == srcB))      valB = valM;
            else if (ok_b && wenE && (dstE == srcB)) valB = valE;
        end
    end

    y86_reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .srcA     (srcA),
        .srcB     (srcB),
        .wenE     (wenE),
        .dstE     (dstE),
        .wenM     (wenM),
        .dstM     (dstM),
        .rsv_en   (rsv_en),
        .rsv_dstE (rsv_dstE),
        .rsv_dstM (rsv_dstM),
        .busyA    (busyA),
        .busyB    (busyB),
        .sb_err   (sb_err)
    );

endmodule

// File: tb/tb_y86_regfile_pipe.sv
// Directed bench for y86_regfile_pipe: one bypassing and one non-bypassing instance
// share stimulus; each vector checks both read ports, busy flags and sb_err.
module tb_y86_regfile_pipe;

    logic        clk;
    logic        rst;
    logic [3:0]  srcA, srcB, dstE, dstM, rsv_dstE, rsv_dstM;
    logic [63:0] valE, valM;
    logic        wenE, wenM, rsv_en;

    logic [63:0] valA_b, valB_b, valA_n, valB_n;
    logic        busyA_b, busyB_b, err_b, busyA_n, busyB_n, err_n;

    int n_pass;
    int n_tot;

    y86_regfile_pipe #(.BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA_b), .valB(valB_b),
        .busyA(busyA_b), .busyB(busyB_b), .wenE(wenE), .dstE(dstE), .valE(valE),
        .wenM(wenM), .dstM(dstM), .valM(valM), .rsv_en(rsv_en), .rsv_dstE(rsv_dstE),
        .rsv_dstM(rsv_dstM), .sb_err(err_b)
    );

    y86_regfile_pipe #(.BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA_n), .valB(valB_n),
        .busyA(busyA_n), .busyB(busyB_n), .wenE(wenE), .dstE(dstE), .valE(valE),
        .wenM(wenM), .dstM(dstM), .valM(valM), .rsv_en(rsv_en), .rsv_dstE(rsv_dstE),
        .rsv_dstM(rsv_dstM), .sb_err(err_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wenE;
        logic [3:0]  dstE;
        logic [63:0] valE;
        logic        wenM;
        logic [3:0]  dstM;
        logic [63:0] valM;
        logic        rsv;
        logic [3:0]  rE;
        logic [3:0]  rM;
        logic [3:0]  sA;
        logic [3:0]  sB;
        logic [63:0] bA;     // expected valA, bypassing instance
        logic [63:0] bB;
        logic        bbA;    // expected busyA, bypassing instance
        logic        bbB;
        logic [63:0] nA;     // expected valA, non-bypassing instance
        logic [63:0] nB;
        logic        nbA;
        logic        nbB;
        logic        err;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        wenE = v.wenE; dstE = v.dstE; valE = v.valE;
        wenM = v.wenM; dstM = v.dstM; valM = v.valM;
        rsv_en = v.rsv; rsv_dstE = v.rE; rsv_dstM = v.rM;
        srcA = v.sA; srcB = v.sB;
    endtask

    task automatic idle(input logic [3:0] a, input logic [3:0] b);
        wenE = 1'b0; dstE = 4'hF; valE = '0;
        wenM = 1'b0; dstM = 4'hF; valM = '0;
        rsv_en = 1'b0; rsv_dstE = 4'hF; rsv_dstM = 4'hF;
        srcA = a; srcB = b;
    endtask

    task automatic chk_all(input string t, input vec_t v);
        chk({t, " byp valA"},  valA_b,  v.bA);
        chk({t, " byp valB"},  valB_b,  v.bB);
        chk({t, " byp busyA"}, 64'(busyA_b), 64'(v.bbA));
        chk({t, " byp busyB"}, 64'(busyB_b), 64'(v.bbB));
        chk({t, " nob valA"},  valA_n,  v.nA);
        chk({t, " nob valB"},  valB_n,  v.nB);
        chk({t, " nob busyA"}, 64'(busyA_n), 64'(v.nbA));
        chk({t, " nob busyB"}, 64'(busyB_n), 64'(v.nbB));
        chk({t, " byp sb_err"}, 64'(err_b), 64'(v.err));
        chk({t, " nob sb_err"}, 64'(err_n), 64'(v.err));
    endtask

    initial begin
        vec_t h;
        logic [63:0] rv;
        n_pass = 0;
        n_tot  = 0;
        rst    = 1'b1;
        idle(4'hF, 4'hF);

        //           wE dE  valE      wM dM  valM   rsv rE   rM    sA    sB    bA        bB        bbA  bbB   nA       nB        nbA  nbB  err
        vecs[0]  = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  1, 4'h3, 4'h3, 4'h3, 4'h4, 64'h0,    64'hFFFF, 0, 0, 64'h0,    64'hFFFF, 0, 0, 0};
        vecs[1]  = '{1, 4'h3, 64'h11,   1, 4'h3, 64'h22, 0, 4'hF, 4'hF, 4'h3, 4'h4, 64'h22,   64'hFFFF, 0, 0, 64'h0,    64'hFFFF, 1, 0, 0};
        vecs[2]  = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h3, 4'h4, 64'h22,   64'hFFFF, 0, 0, 64'h22,   64'hFFFF, 0, 0, 0};
        vecs[3]  = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  1, 4'h2, 4'hF, 4'h3, 4'h2, 64'h22,   64'h0,    0, 0, 64'h22,   64'h0,    0, 0, 0};
        vecs[4]  = '{1, 4'h2, 64'hABCD, 0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h3, 4'h2, 64'h22,   64'hABCD, 0, 0, 64'h22,   64'h0,    0, 1, 0};
        vecs[5]  = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h3, 4'h2, 64'h22,   64'hABCD, 0, 0, 64'h22,   64'hABCD, 0, 0, 0};
        vecs[6]  = '{1, 4'hF, 64'h5,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'hF, 4'h4, 64'h0,    64'hFFFF, 0, 0, 64'h0,    64'hFFFF, 0, 0, 0};
        vecs[7]  = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'hF, 4'h3, 64'h0,    64'h22,   0, 0, 64'h0,    64'h22,   0, 0, 0};
        vecs[8]  = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  1, 4'h7, 4'hF, 4'h7, 4'h3, 64'h0,    64'h22,   0, 0, 64'h0,    64'h22,   0, 0, 0};
        vecs[9]  = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h7, 4'h3, 64'h0,    64'h22,   1, 0, 64'h0,    64'h22,   1, 0, 0};
        vecs[10] = '{1, 4'h7, 64'h77,   0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h7, 4'h3, 64'h77,   64'h22,   0, 0, 64'h0,    64'h22,   1, 0, 0};
        vecs[11] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h7, 4'h3, 64'h77,   64'h22,   0, 0, 64'h77,   64'h22,   0, 0, 0};
        vecs[12] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  1, 4'h7, 4'hF, 4'h7, 4'h3, 64'h77,   64'h22,   0, 0, 64'h77,   64'h22,   0, 0, 0};
        vecs[13] = '{1, 4'h7, 64'h78,   0, 4'hF, 64'h0,  1, 4'h7, 4'hF, 4'h7, 4'h3, 64'h78,   64'h22,   0, 0, 64'h77,   64'h22,   1, 0, 0};
        vecs[14] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h7, 4'h3, 64'h78,   64'h22,   1, 0, 64'h78,   64'h22,   1, 0, 0};
        vecs[15] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  1, 4'h7, 4'h7, 4'h7, 4'h3, 64'h78,   64'h22,   1, 0, 64'h78,   64'h22,   1, 0, 0};
        vecs[16] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  1, 4'h7, 4'hF, 4'h7, 4'h3, 64'h78,   64'h22,   1, 0, 64'h78,   64'h22,   1, 0, 0};
        vecs[17] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h7, 4'h3, 64'h78,   64'h22,   1, 0, 64'h78,   64'h22,   1, 0, 1};
        vecs[18] = '{1, 4'h7, 64'h1,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h7, 4'h3, 64'h1,    64'h22,   1, 0, 64'h78,   64'h22,   1, 0, 1};
        vecs[19] = '{1, 4'h7, 64'h2,    1, 4'h7, 64'h3,  0, 4'hF, 4'hF, 4'h7, 4'h7, 64'h3,    64'h3,    0, 0, 64'h1,    64'h1,    1, 1, 1};
        vecs[20] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h7, 4'h3, 64'h3,    64'h22,   0, 0, 64'h3,    64'h22,   0, 0, 1};
        vecs[21] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  1, 4'h1, 4'h4, 4'h1, 4'h4, 64'h0,    64'hFFFF, 0, 0, 64'h0,    64'hFFFF, 0, 0, 1};
        vecs[22] = '{0, 4'hF, 64'h0,    0, 4'hF, 64'h0,  0, 4'hF, 4'hF, 4'h1, 4'h4, 64'h0,    64'hFFFF, 1, 1, 64'h0,    64'hFFFF, 1, 1, 1};

        // Reset contents: only %rsp is non-zero.
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 15; r++) begin
            @(negedge clk);
            idle(4'(r), 4'(14 - r));
            #1;
            rv = (r == 4) ? 64'hFFFF : 64'h0;
            chk($sformatf("reset r%0d byp valA", r), valA_b, rv);
            chk($sformatf("reset r%0d nob valA", r), valA_n, rv);
            rv = (14 - r == 4) ? 64'hFFFF : 64'h0;
            chk($sformatf("reset r%0d byp valB", 14 - r), valB_b, rv);
            chk($sformatf("reset r%0d busy", r), 64'({busyA_b, busyB_b, busyA_n, busyB_n}), 64'h0);
            chk($sformatf("reset r%0d sb_err", r), 64'({err_b, err_n}), 64'h0);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i]);
        end

        // Reset mid-operation with a write and reservations in the same cycle.
        @(negedge clk);
        idle(4'h1, 4'h4);
        rst = 1'b1;
        wenE = 1'b1; dstE = 4'h4; valE = 64'h99;
        rsv_en = 1'b1; rsv_dstE = 4'h1; rsv_dstM = 4'h5;
        @(negedge clk);
        rst = 1'b0;
        idle(4'h1, 4'h4);
        #1;
        h = '{0, 4'hF, 64'h0, 0, 4'hF, 64'h0, 0, 4'hF, 4'hF, 4'h1, 4'h4,
              64'h0, 64'hFFFF, 0, 0, 64'h0, 64'hFFFF, 0, 0, 0};
        chk_all("rst_mid", h);
        @(negedge clk);
        idle(4'h5, 4'h7);
        #1;
        h = '{0, 4'hF, 64'h0, 0, 4'hF, 64'h0, 0, 4'hF, 4'hF, 4'h5, 4'h7,
              64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0, 0, 0};
        chk_all("rst_mid2", h);

        // Write to an unreserved register: data lands, error latches, counter stays 0.
        @(negedge clk);
        idle(4'hF, 4'h3);
        wenE = 1'b1; dstE = 4'h6; valE = 64'h66;
        @(negedge clk);
        idle(4'h6, 4'h3);
        #1;
        h = '{0, 4'hF, 64'h0, 0, 4'hF, 64'h0, 0, 4'hF, 4'hF, 4'h6, 4'h3,
              64'h66, 64'h0, 0, 0, 64'h66, 64'h0, 0, 0, 1};
        chk_all("underflow", h);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
